wb_burst_ram: RTL and testbench

//  Wishbone B3 slave (responder) backed by an on-chip word RAM. It terminates a dbus-style

---
 rtl/wb_burst_ram.sv | 118 +++++++++++
 tb/tb_wb_burst_ram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave backed by an on-chip word RAM: classic cycles plus
// incrementing bursts (linear/wrap4/wrap8/wrap16) with zero-wait beats.
module wb_burst_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = DW / 8;
    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic {IDLE, BURST} state_t;

    logic [DW-1:0] mem [DEPTH];
    state_t        state;
    logic [AW-1:0] nxt;
    logic          req;

    assign req      = wb_cyc_i & wb_stb_i;
    assign wb_rty_o = 1'b0;

    function automatic logic out_of_range(input logic [AW-1:0] a);
        return |(a >> (IW + 2));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
        return a[IW+1:2];
    endfunction

    // Wrap bursts only increment the low word-index bits inside the aligned block.
    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
        logic [AW-3:0] w;
        logic [AW-3:0] inc;
        logic [AW-3:0] mask;
        w   = a[AW-1:2];
        inc = w + (AW-2)'(1);
        case (bte)
            2'b01:   mask = (AW-2)'(3);
            2'b10:   mask = (AW-2)'(7);
            2'b11:   mask = (AW-2)'(15);
            default: mask = '1;
        endcase
        return {(w & ~mask) | (inc & mask), 2'b00};
    endfunction

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            nxt      <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && !wb_ack_o && !wb_err_o) begin
                        if (out_of_range(wb_adr_i)) begin
                            wb_err_o <= 1'b1;
                        end else begin
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= mem[word_idx(wb_adr_i)];
                            if (wb_cti_i == CTI_INCR) begin
                                state <= BURST;
                                nxt   <= next_adr(wb_adr_i, wb_bte_i);
                            end
                        end
                    end
                end
                BURST: begin
                    // The current beat is being acked; prefetch the predicted one.
                    if (req && wb_cti_i == CTI_INCR) begin
                        if (out_of_range(nxt)) begin
                            wb_err_o <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= mem[word_idx(nxt)];
                            nxt      <= next_adr(nxt, wb_bte_i);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: RAM has no reset so it maps onto block RAM; reset only gates the write.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && req && wb_we_i && wb_ack_o) begin
            for (int i = 0; i < SW; i++) begin
                if (wb_sel_i[i]) begin
                    mem[word_idx(wb_adr_i)][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram: a table of classic accesses followed by
// hand-written burst, wrap, run-off error and mid-burst reset sequences.
module tb_wb_burst_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_burst_ram #(.DW(32), .DEPTH(256), .AW(32)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic        exp_err;
        logic [31:0] exp_rdat;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = '0;
        dat_i = '0;
        sel   = '0;
        cti   = 3'b000;
        bte   = 2'b00;
    endtask

    // Classic access: response must appear one cycle after the strobe and
    // must not repeat while the strobe is still held for one more cycle.
    task automatic classic(input string name, input vec_t v);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = v.we;
        adr   = v.adr;
        dat_i = v.wdat;
        sel   = v.sel;
        cti   = v.cti;
        bte   = 2'b00;
        @(posedge clk); #1;
        check({name, ".ack"}, 32'(ack), 32'(!v.exp_err));
        check({name, ".err"}, 32'(err), 32'(v.exp_err));
        if (v.exp_err) check({name, ".rty"}, 32'(rty), 32'd0);
        if (!v.we && !v.exp_err) check({name, ".dat"}, dat_o, v.exp_rdat);
        @(posedge clk); #1;
        check({name, ".ack2"}, 32'(ack), 32'd0);
        check({name, ".err2"}, 32'(err), 32'd0);
        bus_idle();
    endtask

    function automatic logic [31:0] wrap_next(input logic [31:0] a, input logic [1:0] b);
        logic [31:0] blk;
        case (b)
            2'b01:   blk = 32'd16;
            2'b10:   blk = 32'd32;
            2'b11:   blk = 32'd64;
            default: return a + 32'd4;
        endcase
        return (a & ~(blk - 32'd1)) | ((a + 32'd4) & (blk - 32'd1));
    endfunction

    // Burst of n beats, data base+i; err_beat >= 0 marks the beat expected to error.
    task automatic burst(input string name, input logic [31:0] start, input logic [1:0] b,
                         input int n, input logic w, input logic [31:0] base, input int err_beat);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            cyc   = 1'b1;
            stb   = 1'b1;
            we    = w;
            adr   = a;
            dat_i = base + 32'(i);
            sel   = 4'hF;
            cti   = (i == n - 1) ? 3'b111 : 3'b010;
            bte   = b;
            if (i == 0) begin
                @(posedge clk); #1;
            end
            if (i == err_beat) begin
                check($sformatf("%s.err%0d", name, i), 32'(err), 32'd1);
                check($sformatf("%s.noack%0d", name, i), 32'(ack), 32'd0);
                @(posedge clk); #1;
                break;
            end
            check($sformatf("%s.ack%0d", name, i), 32'(ack), 32'd1);
            if (!w) check($sformatf("%s.dat%0d", name, i), dat_o, base + 32'(i));
            @(posedge clk); #1;
            a = wrap_next(a, b);
        end
        bus_idle();
        check({name, ".end_ack"}, 32'(ack), 32'd0);
        check({name, ".end_err"}, 32'(err), 32'd0);
    endtask

    function automatic vec_t rd(input logic [31:0] a, input logic [31:0] d);
        return '{1'b0, a, 32'h0, 4'h0, 3'b000, 1'b0, d};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        we    adr        wdat          sel    cti     err   rdat
        vt[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h010, 32'h0,        4'h0, 3'b000, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h020, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h020, 32'h11223344, 4'h5, 3'b000, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h020, 32'h0,        4'h0, 3'b000, 1'b0, 32'hFF22FF44};
        vt[5]  = '{1'b1, 32'h040, 32'hB0000000, 4'hF, 3'b111, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 32'h044, 32'hB0000001, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 32'h048, 32'hB0000002, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 32'h04C, 32'hB0000003, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'h3F8, 32'hC0000000, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[10] = '{1'b1, 32'h3FC, 32'hC0000001, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[11] = '{1'b0, 32'h3FF, 32'h0,        4'h0, 3'b000, 1'b0, 32'hC0000001};
        vt[12] = '{1'b1, 32'h000, 32'h0000AAAA, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[13] = '{1'b0, 32'h400, 32'h0,        4'h0, 3'b000, 1'b1, 32'h0};
        vt[14] = '{1'b1, 32'h400, 32'h55555555, 4'hF, 3'b000, 1'b1, 32'h0};
        vt[15] = '{1'b0, 32'h000, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0000AAAA};
        vt[16] = '{1'b1, 32'h084, 32'h12345678, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[17] = '{1'b1, 32'h080, 32'h87654321, 4'hF, 3'b000, 1'b0, 32'h0};
        vt[18] = '{1'b0, 32'h020, 32'h0,        4'h0, 3'b011, 1'b0, 32'hFF22FF44};

        bus_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ack", 32'(ack), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        check("reset.dat", dat_o, 32'h0);
        check("reset.rty", 32'(rty), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            classic($sformatf("vec%0d", i), vt[i]);
        end

        burst("lin4_rd", 32'h040, 2'b00, 4, 1'b0, 32'hB0000000, -1);

        burst("wrap4_wr", 32'h038, 2'b01, 4, 1'b1, 32'd1, -1);
        classic("wrap4_30", rd(32'h030, 32'd3));
        classic("wrap4_34", rd(32'h034, 32'd4));
        classic("wrap4_38", rd(32'h038, 32'd1));
        classic("wrap4_3c", rd(32'h03C, 32'd2));

        burst("wrap8_wr", 32'h05C, 2'b10, 4, 1'b1, 32'h60000000, -1);
        classic("wrap8_40", rd(32'h040, 32'h60000001));
        classic("wrap8_4c", rd(32'h04C, 32'hB0000003));
        classic("wrap8_5c", rd(32'h05C, 32'h60000000));

        burst("runoff", 32'h3F8, 2'b00, 3, 1'b0, 32'hC0000000, 2);

        // Reset lands while the second beat of an 8-beat write burst is acked.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = 2'b00;
        cti = 3'b010; adr = 32'h080; dat_i = 32'h50000000;
        @(posedge clk); #1;
        check("rstmid.ack0", 32'(ack), 32'd1);
        @(posedge clk); #1;
        adr = 32'h084; dat_i = 32'h50000001;
        check("rstmid.ack1", 32'(ack), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        check("rstmid.ack", 32'(ack), 32'd0);
        check("rstmid.err", 32'(err), 32'd0);
        check("rstmid.dat", dat_o, 32'h0);
        classic("rstmid_80", rd(32'h080, 32'h50000000));
        classic("rstmid_84", rd(32'h084, 32'h12345678));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
